kbd_event_fifo: RTL and testbench

- Consumes raw PS/2 scan-code bytes from ps2_keyboard through the ready/nextdata_n handshake.
- Parses E0/F0 prefixes and tracks the shift, ctrl and caps-lock modifiers.
- Pushes complete 16-bit key events into a first-word-fall-through FIFO.
- The CPU reads the FIFO through the dmem_kbd mapped region; this block sits between ps2_keyboard and the dmem read mux.

---
 rtl/kbd_event_fifo.sv | 176 +++++++++++++++++
 tb/tb_kbd_event_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: pulls PS/2 scan-code bytes from ps2_keyboard, decodes E0/F0
// prefixes and modifier state, and queues 16-bit key events in a
// first-word-fall-through FIFO that the CPU reads through the dmem_kbd region.
module kbd_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_ready,
  output logic              ps2_nextdata_n,
  input  logic              evt_pop,
  output logic              evt_valid,
  output logic [15:0]       evt_data,
  output logic [ADDR_W:0]   evt_count,
  output logic              overflow,
  input  logic              clr_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic              nextdata_n_q;
  logic              shift_q, shift_d, ctrl_q, ctrl_d;
  logic              caps_q, caps_d, caps_held_q, caps_held_d;
  logic [8:0]        last_make_q, last_make_d;
  logic              last_vld_q, last_vld_d;
  logic              take, evt_push, is_brk, is_ext, rpt;
  logic [15:0]       evt_word;

  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic              full, pop_ok, push_ok, drop;

  // Bytes the keyboard sends for status/acks; never turned into events from IDLE.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ignored = 1'b1;
      default:                                  is_ignored = 1'b0;
    endcase
  endfunction

  // A byte is accepted only while the strobe is idle, so intake is one byte per two cycles.
  assign take = ps2_ready & nextdata_n_q;

  // Prefix decoding, modifier tracking, repeat detection and event assembly.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    last_make_d = last_make_q;
    last_vld_d  = last_vld_q;
    evt_push    = 1'b0;
    is_brk      = 1'b0;
    is_ext      = 1'b0;
    rpt         = 1'b0;
    if (take) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_data == 8'hE0)      state_d = S_E0;
          else if (ps2_data == 8'hF0) state_d = S_F0;
          else if (!is_ignored(ps2_data)) evt_push = 1'b1;
        end
        S_E0: begin
          if (ps2_data == 8'hF0)      state_d = S_E0F0;
          else if (ps2_data != 8'hE0) begin evt_push = 1'b1; is_ext = 1'b1; end
        end
        S_F0: begin
          if (ps2_data == 8'hE0)      state_d = S_E0;
          else if (ps2_data != 8'hF0) begin evt_push = 1'b1; is_brk = 1'b1; end
        end
        default: begin
          if (ps2_data != 8'hE0 && ps2_data != 8'hF0) begin
            evt_push = 1'b1;
            is_brk   = 1'b1;
            is_ext   = 1'b1;
          end
        end
      endcase
      if (evt_push) begin
        state_d = S_IDLE;
        if (!is_ext && (ps2_data == 8'h12 || ps2_data == 8'h59)) shift_d = ~is_brk;
        if (ps2_data == 8'h14) ctrl_d = ~is_brk;
        if (!is_ext && ps2_data == 8'h58) begin
          if (is_brk) caps_held_d = 1'b0;
          else begin
            if (!caps_held_q) caps_d = ~caps_q;
            caps_held_d = 1'b1;
          end
        end
        if (!is_brk) begin
          rpt         = last_vld_q && (last_make_q == {is_ext, ps2_data});
          last_make_d = {is_ext, ps2_data};
          last_vld_d  = 1'b1;
        end else if (last_vld_q && last_make_q == {is_ext, ps2_data}) begin
          last_vld_d  = 1'b0;
        end
      end
    end
    evt_word = {is_brk, is_ext, rpt, shift_d, ctrl_d, caps_d, 2'b00, ps2_data};
  end

  // Handshake strobe and parser/modifier state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      nextdata_n_q <= 1'b1;
      state_q      <= S_IDLE;
      shift_q      <= 1'b0;
      ctrl_q       <= 1'b0;
      caps_q       <= 1'b0;
      caps_held_q  <= 1'b0;
      last_make_q  <= '0;
      last_vld_q   <= 1'b0;
    end else begin
      nextdata_n_q <= ~take;
      state_q      <= state_d;
      shift_q      <= shift_d;
      ctrl_q       <= ctrl_d;
      caps_q       <= caps_d;
      caps_held_q  <= caps_held_d;
      last_make_q  <= last_make_d;
      last_vld_q   <= last_vld_d;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full    = (count_q == FULL_CNT);
  assign pop_ok  = evt_pop & (count_q != '0);
  assign push_ok = evt_push & (~full | evt_pop);
  assign drop    = evt_push & full & ~evt_pop;

  // Occupancy follows accepted pushes and pops.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Event storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= evt_word;
  end

  // Pointers, occupancy and sticky overflow (a drop wins over clr_ovf).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop)         overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign evt_valid      = (count_q != '0);
  assign evt_data       = evt_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign evt_count      = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Testbench for kbd_event_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_kbd_event_fifo;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        ps2_data = 8'h00;
  logic              ps2_ready = 1'b0;
  logic              ps2_nextdata_n;
  logic              evt_pop = 1'b0;
  logic              evt_valid;
  logic [15:0]       evt_data;
  logic [ADDR_W:0]   evt_count;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  kbd_event_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_nextdata_n(ps2_nextdata_n), .evt_pop(evt_pop), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // stimulus controls
  bit rdy_en = 1, pop_r = 0, clr_r = 0, rst_r = 1;
  logic [7:0] src_q[$];

  // reference model state
  bit m_e0, m_f0, m_shift, m_ctrl, m_caps, m_held, m_lv, m_nd, m_ovf;
  bit [8:0] m_last;
  logic [15:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit ignored_byte(input logic [7:0] b);
    return (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF);
  endfunction

  task automatic model_update(input bit rdy, input logic [7:0] b, input bit pop, input bit clr, input bit rst);
    bit take, ev, brk, ext, rpt, popped, set_ovf;
    int had;
    if (rst) begin
      m_e0 = 0; m_f0 = 0; m_shift = 0; m_ctrl = 0; m_caps = 0; m_held = 0;
      m_lv = 0; m_last = '0; m_nd = 1; m_ovf = 0;
      m_q.delete();
      return;
    end
    take = rdy && m_nd;
    m_nd = !take;
    ev = 0; brk = 0; ext = 0; rpt = 0; set_ovf = 0;
    if (take) begin
      if (b == 8'hE0) begin
        if (!(m_e0 && m_f0)) begin m_e0 = 1; m_f0 = 0; end
      end else if (b == 8'hF0) begin
        m_f0 = 1;
      end else if (!(!m_e0 && !m_f0 && ignored_byte(b))) begin
        ev = 1; ext = m_e0; brk = m_f0; m_e0 = 0; m_f0 = 0;
      end
    end
    if (ev) begin
      if (!ext && (b == 8'h12 || b == 8'h59)) m_shift = !brk;
      if (b == 8'h14) m_ctrl = !brk;
      if (!ext && b == 8'h58) begin
        if (!brk) begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1;
        end else m_held = 0;
      end
      if (!brk) begin
        rpt = m_lv && (m_last == {ext, b});
        m_last = {ext, b}; m_lv = 1;
      end else if (m_lv && m_last == {ext, b}) m_lv = 0;
    end
    had = m_q.size();
    popped = pop && had > 0;
    if (popped) void'(m_q.pop_front());
    if (ev) begin
      if (had < DEPTH || popped) m_q.push_back({brk, ext, rpt, m_shift, m_ctrl, m_caps, 2'b00, b});
      else set_ovf = 1;
    end
    if (set_ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (take) void'(src_q.pop_front());
  endtask

  // One clock: compare against the model, drive the next inputs, advance the model.
  task automatic step();
    logic [15:0] exp_data;
    @(negedge clock);
    if (chk_en) begin
      exp_data = (m_q.size() > 0) ? m_q[0] : 16'h0000;
      check_eq("nextdata_n", 32'(ps2_nextdata_n), 32'(m_nd));
      check_eq("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      check_eq("evt_data", 32'(evt_data), 32'(exp_data));
      check_eq("evt_count", 32'(evt_count), 32'(m_q.size()));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
    end
    reset     = rst_r;
    ps2_ready = rdy_en && (src_q.size() > 0);
    ps2_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    evt_pop   = pop_r;
    clr_ovf   = clr_r;
    model_update(ps2_ready, ps2_data, evt_pop, clr_ovf, reset);
    @(posedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((src_q.size() > 0 || !m_nd) && n < 200) begin step(); n++; end
    if (n >= 200) check_eq("drain_timeout", 32'(n), 32'(0));
  endtask

  task automatic flush();
    int n = 0;
    pop_r = 1;
    while (m_q.size() > 0 && n < 40) begin step(); n++; end
    pop_r = 0;
    step();
  endtask

  task automatic feed(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    #1 check_eq(tag, 32'(evt_data), 32'(exp));
    pop_r = 1; step(); pop_r = 0;
  endtask

  logic [7:0] mods [4]  = '{8'h12, 8'h59, 8'h14, 8'h58};
  logic [7:0] igns [6]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  logic [7:0] codes[6]  = '{8'h1C, 8'h1D, 8'h6B, 8'h75, 8'h23, 8'h2B};
  logic [7:0] ovf_codes[9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

  initial begin
    // reset
    rst_r = 1; step(); chk_en = 1; step(); rst_r = 0;
    #1;
    check_eq("rst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_data", 32'(evt_data), 32'd0);
    check_eq("rst_count", 32'(evt_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);

    // make/break of 1C
    feed(8'h1C); feed(8'hF0); feed(8'h1C); drain();
    #1 check_eq("t1_count", 32'(evt_count), 32'd2);
    pop_expect("t1_make", 16'h001C);
    pop_expect("t1_break", 16'h801C);

    // shift and repeat flag
    feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h12); feed(8'h1C); drain();
    pop_expect("t2_shift", 16'h1012);
    pop_expect("t2_1c", 16'h101C);
    pop_expect("t2_shift_brk", 16'h8012);
    pop_expect("t2_rpt", 16'h201C);

    // extended keys and caps lock
    feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75); drain();
    pop_expect("t3_ext_make", 16'h4075);
    pop_expect("t3_ext_brk", 16'hC075);
    feed(8'h58); feed(8'h58); feed(8'hF0); feed(8'h58); feed(8'h58); drain();
    pop_expect("t3_caps_on", 16'h0458);
    pop_expect("t3_caps_rpt", 16'h2458);
    pop_expect("t3_caps_brk", 16'h8458);
    pop_expect("t3_caps_off", 16'h0058);

    // overflow, push+pop while full, clear
    flush();
    foreach (ovf_codes[i]) feed(ovf_codes[i]);
    drain();
    #1 check_eq("t4_full_count", 32'(evt_count), 32'd8);
    check_eq("t4_overflow", 32'(overflow), 32'd1);
    feed(8'h4B); pop_r = 1; step(); pop_r = 0;
    #1 check_eq("t4_pushpop_count", 32'(evt_count), 32'd8);
    check_eq("t4_pushpop_head", 32'(evt_data), 32'h001D);
    check_eq("t4_ovf_kept", 32'(overflow), 32'd1);
    clr_r = 1; step(); clr_r = 0;
    #1 check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
    flush();

    // ignored bytes and malformed F0 E0
    feed(8'hAA); feed(8'hFA); feed(8'hF0); feed(8'hE0); feed(8'h6B); drain();
    #1 check_eq("t5_count", 32'(evt_count), 32'd1);
    pop_expect("t5_evt", 16'h406B);

    // reset mid-handshake discards the E0 prefix
    feed(8'hE0); step();
    rst_r = 1; step(); rst_r = 0;
    #1 check_eq("t6_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    check_eq("t6_count", 32'(evt_count), 32'd0);
    feed(8'h6B); drain();
    pop_expect("t6_evt", 16'h006B);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (src_q.size() < 3 && ($urandom % 2 == 0)) begin
        case ($urandom_range(0, 9))
          0: feed(8'hE0);
          1, 2: feed(8'hF0);
          3: feed(mods[$urandom_range(0, 3)]);
          4: feed(igns[$urandom_range(0, 5)]);
          default: feed(codes[$urandom_range(0, 5)]);
        endcase
      end
      rdy_en = ($urandom % 4) != 0;
      pop_r  = ($urandom % 3) == 0;
      clr_r  = ($urandom % 25) == 0;
      rst_r  = ($urandom % 700) == 0;
      step();
    end
    rdy_en = 1; pop_r = 0; clr_r = 0; rst_r = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
